// File: rtl/rcu_pll_seq_pkg.sv
// Shared definitions for the RCU PLL sequencer: FSM state encoding and
// default sizing constants used by the sequencer and its divider channels.
package rcu_pll_seq_pkg;

  localparam int STATE_W         = 3;
  localparam int DEF_LOCK_CNT    = 64;
  localparam int DEF_TIMEOUT_CYC = 4096;
  localparam int DEF_DIV_WIDTH   = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_LOCKED    = 3'd3,
    ST_ERROR     = 3'd4
  } rcu_pll_state_e;

endpackage

// File: rtl/rcu_clk_div.sv
// One programmable integer divider channel: produces a one-cycle strobe every
// shadow+1 cycles and a registered clock toggling on each strobe.
module rcu_clk_div
  import rcu_pll_seq_pkg::*;
#(
  parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 run_i,
  input  logic [DIV_WIDTH-1:0] div_val_i,
  output logic                 stb_o,
  output logic                 clk_o
);

  logic [DIV_WIDTH-1:0] cnt_reg;
  logic [DIV_WIDTH-1:0] shadow_reg;
  logic                 stb_reg;
  logic                 clk_reg;

  // The shadow only follows div_val_i while idle or at a wrap, so a new value
  // never shortens the period already in progress.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_reg    <= '0;
      shadow_reg <= '0;
      stb_reg    <= 1'b0;
      clk_reg    <= 1'b0;
    end else if (!run_i) begin
      cnt_reg    <= '0;
      shadow_reg <= div_val_i;
      stb_reg    <= 1'b0;
      clk_reg    <= 1'b0;
    end else if (cnt_reg == shadow_reg) begin
      cnt_reg    <= '0;
      shadow_reg <= div_val_i;
      stb_reg    <= 1'b1;
      clk_reg    <= ~clk_reg;
    end else begin
      cnt_reg    <= cnt_reg + DIV_WIDTH'(1);
      stb_reg    <= 1'b0;
    end
  end

  assign stb_o = stb_reg;
  assign clk_o = clk_reg;

endmodule

// File: rtl/rcu_pll_seq.sv
// RCU PLL sequencer: synchronises and qualifies the raw PLL lock, runs the
// PLL-select handshake with a lock timeout, and drives NUM_DIV dividers.
module rcu_pll_seq
  import rcu_pll_seq_pkg::*;
#(
  parameter int NUM_DIV       = 4,
  parameter int DIV_WIDTH     = DEF_DIV_WIDTH,
  parameter int LOCK_CNT      = DEF_LOCK_CNT,
  parameter int TIMEOUT_CYC   = DEF_TIMEOUT_CYC,
  parameter int SYNC_STAGES   = 2,
  parameter bit DIV_NEED_LOCK = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         pll_en_i,
  input  logic                         pll_lock_raw_i,
  input  logic [NUM_DIV-1:0]           div_en_i,
  input  logic [NUM_DIV*DIV_WIDTH-1:0] div_val_i,
  output logic                         pll_lock_o,
  output logic                         pll_sel_o,
  output logic                         lock_err_o,
  output logic                         lock_lost_o,
  output logic [STATE_W-1:0]           state_o,
  output logic [NUM_DIV-1:0]           div_stb_o,
  output logic [NUM_DIV-1:0]           div_clk_o
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam int STB_W = $clog2(LOCK_CNT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_CNT - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   lock_s;

  rcu_pll_state_e   state_reg, state_next;
  logic [TMR_W-1:0] timer_reg, timer_next, timer_inc;
  logic [STB_W-1:0] stab_reg, stab_next;
  logic             lock_err_reg, lock_err_next;
  logic             lock_lost_reg, lock_lost_next;
  logic             pll_lock_reg, pll_sel_reg;
  logic [NUM_DIV-1:0] div_run;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sync_reg <= '0;
    else          sync_reg <= {sync_reg[SYNC_STAGES-2:0], pll_lock_raw_i};
  end

  assign lock_s    = sync_reg[SYNC_STAGES-1];
  assign timer_inc = (timer_reg == TMR_LAST) ? timer_reg : timer_reg + TMR_W'(1);

  always_comb begin
    state_next     = state_reg;
    timer_next     = timer_reg;
    stab_next      = stab_reg;
    lock_err_next  = lock_err_reg;
    lock_lost_next = lock_lost_reg;
    case (state_reg)
      ST_IDLE: begin
        timer_next = '0;
        stab_next  = '0;
        if (pll_en_i) state_next = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        timer_next = timer_inc;
        if (!pll_en_i)               state_next = ST_IDLE;
        else if (timer_reg == TMR_LAST) state_next = ST_ERROR;
        else if (lock_s) begin
          state_next = ST_STABLE;
          stab_next  = '0;
        end
      end
      ST_STABLE: begin
        // Timer is deliberately not restarted on a STABLE->WAIT_LOCK bounce.
        timer_next = timer_inc;
        if (lock_s) stab_next = stab_reg + STB_W'(1);
        if (!pll_en_i)                  state_next = ST_IDLE;
        else if (timer_reg == TMR_LAST) state_next = ST_ERROR;
        else if (!lock_s)               state_next = ST_WAIT_LOCK;
        else if (stab_reg == STB_LAST)  state_next = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (!pll_en_i) state_next = ST_IDLE;
        else if (!lock_s) begin
          state_next     = ST_WAIT_LOCK;
          lock_lost_next = 1'b1;
          timer_next     = '0;
        end
      end
      ST_ERROR: begin
        if (!pll_en_i) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (state_next == ST_ERROR) lock_err_next = 1'b1;
    if (state_next == ST_IDLE) begin
      lock_err_next  = 1'b0;
      lock_lost_next = 1'b0;
    end
  end

  // Status outputs are registered from the next state so they change on the
  // same edge as state_o.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg     <= ST_IDLE;
      timer_reg     <= '0;
      stab_reg      <= '0;
      lock_err_reg  <= 1'b0;
      lock_lost_reg <= 1'b0;
      pll_lock_reg  <= 1'b0;
      pll_sel_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      stab_reg      <= stab_next;
      lock_err_reg  <= lock_err_next;
      lock_lost_reg <= lock_lost_next;
      pll_lock_reg  <= (state_next == ST_LOCKED);
      pll_sel_reg   <= (state_next == ST_LOCKED);
    end
  end

  assign pll_lock_o  = pll_lock_reg;
  assign pll_sel_o   = pll_sel_reg;
  assign lock_err_o  = lock_err_reg;
  assign lock_lost_o = lock_lost_reg;
  assign state_o     = state_reg;

  assign div_run = div_en_i & {NUM_DIV{pll_lock_reg | !DIV_NEED_LOCK}};

  for (genvar gi = 0; gi < NUM_DIV; gi++) begin : g_div
    rcu_clk_div #(
      .DIV_WIDTH (DIV_WIDTH)
    ) u_div (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .run_i     (div_run[gi]),
      .div_val_i (div_val_i[gi*DIV_WIDTH +: DIV_WIDTH]),
      .stb_o     (div_stb_o[gi]),
      .clk_o     (div_clk_o[gi])
    );
  end

endmodule

// File: tb/tb_rcu_pll_seq.sv
// Directed bench for rcu_pll_seq: lock bring-up, glitch, loss, timeout,
// divider periods and asynchronous reset, with hand-computed expectations.
module tb_rcu_pll_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pll_en;
  logic        pll_lock_raw;
  logic [3:0]  div_en;
  logic [31:0] div_val;
  logic        pll_lock, pll_sel, lock_err, lock_lost;
  logic [2:0]  state;
  logic [3:0]  div_stb, div_clk;

  int n_total = 0;
  int n_pass  = 0;
  int n;

  rcu_pll_seq dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .pll_en_i       (pll_en),
    .pll_lock_raw_i (pll_lock_raw),
    .div_en_i       (div_en),
    .div_val_i      (div_val),
    .pll_lock_o     (pll_lock),
    .pll_sel_o      (pll_sel),
    .lock_err_o     (lock_err),
    .lock_lost_o    (lock_lost),
    .state_o        (state),
    .div_stb_o      (div_stb),
    .div_clk_o      (div_clk)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else begin
      n_pass++;
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic tick(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_lock(input int limit, output int waited);
    waited = 0;
    while (!pll_lock && waited < limit) begin
      tick(1);
      waited++;
    end
  endtask

  initial begin
    rst_n = 1'b0; pll_en = 1'b0; pll_lock_raw = 1'b0; div_en = '0; div_val = '0;
    #12;
    check("rst_lock", pll_lock, 0);
    check("rst_sel", pll_sel, 0);
    check("rst_err", lock_err, 0);
    check("rst_lost", lock_lost, 0);
    check("rst_state", state, 0);
    check("rst_stb", div_stb, 0);
    check("rst_dclk", div_clk, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Bring-up: lock rises 10 cycles after enable, qualified at 10+2+64+1.
    pll_en = 1'b1;
    tick(1);  check("up_wait", state, 1);
    tick(9);  pll_lock_raw = 1'b1;
    tick(2);  check("up_presync", state, 1);
    tick(1);  check("up_stable", state, 2);
    wait_lock(200, n);
    check("up_latency", 32'(13 + n), 77);
    check("up_sel", pll_sel, 1);
    check("up_state", state, 3);
    check("up_err", lock_err, 0);

    // Lock loss in LOCKED, then relock.
    pll_lock_raw = 1'b0;
    tick(2);  check("loss_sel_hold", pll_sel, 1);
    tick(1);
    check("loss_sel", pll_sel, 0);
    check("loss_lock", pll_lock, 0);
    check("loss_lost", lock_lost, 1);
    check("loss_state", state, 1);
    pll_lock_raw = 1'b1;
    wait_lock(200, n);
    check("relock_latency", n, 67);
    check("relock_lost", lock_lost, 1);
    check("relock_state", state, 3);

    // Dividers: ch0 = 3, ch1 = 0; value set a cycle ahead so the shadow holds it.
    div_val = 32'h0000_0003;
    tick(1);
    div_en = 4'b0011;
    for (int k = 1; k <= 13; k++) begin
      tick(1);
      check($sformatf("d0_stb_k%0d", k), div_stb[0], (k % 4) == 0);
      check($sformatf("d0_clk_k%0d", k), div_clk[0], (k / 4) % 2);
      check($sformatf("d1_stb_k%0d", k), div_stb[1], 1);
      check($sformatf("d1_clk_k%0d", k), div_clk[1], k % 2);
    end
    check("d23_idle", {div_stb[3:2], div_clk[3:2]}, 0);
    div_val = 32'h0000_0001;
    for (int k = 14; k <= 23; k++) begin
      tick(1);
      check($sformatf("d0n_stb_k%0d", k), div_stb[0], (k >= 16) && (k % 2 == 0));
      check($sformatf("d0n_clk_k%0d", k), div_clk[0], (k < 16) ? 1 : ((k - 16) / 2) % 2);
    end
    div_en = 4'b0010;
    tick(1);
    check("d0_off_stb", div_stb[0], 0);
    check("d0_off_clk", div_clk[0], 0);
    check("d1_still", div_stb[1], 1);

    // Asynchronous reset mid-operation.
    #3;
    rst_n = 1'b0; pll_en = 1'b0; pll_lock_raw = 1'b0; div_en = '0;
    #1;
    check("arst_lock", pll_lock, 0);
    check("arst_sel", pll_sel, 0);
    check("arst_lost", lock_lost, 0);
    check("arst_state", state, 0);
    check("arst_stb", div_stb, 0);
    check("arst_dclk", div_clk, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("arst_rel_state", state, 0);
    tick(3);
    check("arst_idle", state, 0);

    // Glitch in STABLE: one low cycle restarts the qualification count.
    pll_en = 1'b1; pll_lock_raw = 1'b1;
    tick(30); pll_lock_raw = 1'b0;
    tick(1);  pll_lock_raw = 1'b1;
    tick(1);  check("gl_stable", state, 2);
    tick(1);  check("gl_back_wait", state, 1);
    tick(1);  check("gl_restable", state, 2);
    wait_lock(200, n);
    check("gl_latency", 32'(3 + n), 67);
    check("gl_lost", lock_lost, 0);

    // Timeout with raw lock held low.
    pll_en = 1'b0; pll_lock_raw = 1'b0;
    tick(4);  check("to_idle", state, 0);
    pll_en = 1'b1;
    tick(1);    check("to_wait", state, 1);
    tick(4095); check("to_last_wait", state, 1);
    check("to_no_err", lock_err, 0);
    tick(1);
    check("to_state", state, 4);
    check("to_err", lock_err, 1);
    check("to_sel", pll_sel, 0);
    tick(5);  check("to_err_sticky", lock_err, 1);
    pll_en = 1'b0;
    tick(1);
    check("to_clr_state", state, 0);
    check("to_clr_err", lock_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
